// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin sequencer for the shared 16-bit internal CPU bus.
// Drivers: bit3 ALU, bit2 MDR, bit1 PC, bit0 MARMUX. Registered one-hot grant,
// one dead cycle between owners, and a hold limit enforced only under contention.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [3:0] gate_sel,
    output logic       bus_busy,
    output logic       preempt
);

    localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

    typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic       preempt_q, preempt_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] idx;
    logic       other_req;

    // Round-robin search. Order ALU(3) -> MDR(2) -> PC(1) -> MARMUX(0) -> ALU is a
    // descending index, so the entry after last is last-1. The last owner itself
    // is checked last (i == 4 wraps back to last_q).
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        idx       = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q - 2'(i);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Contention check: any requester other than the current owner.
    always_comb begin
        other_req = |(req & ~(4'b0001 << last_q));
    end

    // Next-state logic: arbitration from IDLE/GAP, release/preempt from OWN.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        unique case (state_q)
            StIdle, StGap: begin
                if (win_found) begin
                    state_d = StOwn;
                    grant_d = 4'b0001 << win_idx;
                    last_d  = win_idx;
                    hold_d  = 8'd1;
                end else begin
                    state_d = StIdle;
                    grant_d = 4'b0000;
                end
            end
            StOwn: begin
                if (!req[last_q]) begin
                    // Voluntary release wins even when the limit is hit on the same edge.
                    state_d = StGap;
                    grant_d = 4'b0000;
                end else if (hold_q == MaxHold && other_req) begin
                    state_d   = StGap;
                    grant_d   = 4'b0000;
                    preempt_d = 1'b1;
                end else if (hold_q < MaxHold) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            grant_q   <= 4'b0000;
            last_q    <= 2'd0;
            hold_q    <= 8'd0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        grant    = grant_q;
        gate_sel = grant_q;
        bus_busy = |grant_q;
        preempt  = preempt_q;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: three instances with
// MAX_HOLD = 8 (default), 4 and 3 share clock and reset.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req8 = 4'b0000;
    logic [3:0] req4 = 4'b0000;
    logic [3:0] req3 = 4'b0000;

    logic [3:0] grant8, gsel8, grant4, gsel4, grant3, gsel3;
    logic       busy8, pre8, busy4, pre4, busy3, pre3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] rot_exp [12];

    always #5 clk = ~clk;

    bus_arbiter dut8 (
        .Clk(clk), .Reset(rst), .req(req8),
        .grant(grant8), .gate_sel(gsel8), .bus_busy(busy8), .preempt(pre8)
    );

    bus_arbiter #(.MAX_HOLD(4)) dut4 (
        .Clk(clk), .Reset(rst), .req(req4),
        .grant(grant4), .gate_sel(gsel4), .bus_busy(busy4), .preempt(pre4)
    );

    bus_arbiter #(.MAX_HOLD(3)) dut3 (
        .Clk(clk), .Reset(rst), .req(req3),
        .grant(grant3), .gate_sel(gsel3), .bus_busy(busy3), .preempt(pre3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rot_exp = '{4'b1000, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b0000,
                    4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0000};

        // Reset state
        tick();
        tick();
        chk("reset_grant", grant8, 4'b0000);
        chk("reset_gsel", gsel8, 4'b0000);
        chk("reset_busy", {3'b0, busy8}, 4'b0000);
        chk("reset_preempt", {3'b0, pre8}, 4'b0000);
        rst = 1'b0;

        // Single requester: PC alone for five grant cycles
        req8 = 4'b0010;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("single_grant_c%0d", i), grant8, 4'b0010);
            chk($sformatf("single_busy_c%0d", i), {3'b0, busy8}, 4'b0001);
        end
        req8 = 4'b0000;
        tick();
        chk("single_gap", grant8, 4'b0000);
        chk("single_gap_preempt", {3'b0, pre8}, 4'b0000);
        tick();
        chk("single_idle", grant8, 4'b0000);

        // Full rotation after a fresh reset, each owner holds two cycles
        rst  = 1'b1;
        #2;
        req8 = 4'b1111;
        rst  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("rot_c%0d", i), grant8, rot_exp[i]);
            chk($sformatf("rot_gsel_c%0d", i), gsel8, rot_exp[i]);
            if (i % 3 == 1) req8 = req8 & ~rot_exp[i];
        end

        // Asynchronous reset mid-cycle while MDR owns
        req8 = 4'b0100;
        tick();
        chk("async_pre_grant", grant8, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        chk("async_grant", grant8, 4'b0000);
        chk("async_gsel", gsel8, 4'b0000);
        chk("async_busy", {3'b0, busy8}, 4'b0000);
        chk("async_preempt", {3'b0, pre8}, 4'b0000);
        req8 = 4'b1111;
        #1;
        rst = 1'b0;
        tick();
        chk("async_first_grant", grant8, 4'b1000);
        req8 = 4'b0000;
        tick();
        tick();

        // Forced release on dut4: ALU continuous, MARMUX from cycle 2
        req4 = 4'b1000;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("force_grant_c%0d", i), grant4, 4'b1000);
            chk($sformatf("force_preempt_c%0d", i), {3'b0, pre4}, 4'b0000);
            if (i == 2) req4 = 4'b1001;
        end
        tick();
        chk("force_gap_grant", grant4, 4'b0000);
        chk("force_gap_busy", {3'b0, busy4}, 4'b0000);
        chk("force_gap_preempt", {3'b0, pre4}, 4'b0001);
        tick();
        chk("force_next_grant", grant4, 4'b0001);
        chk("force_next_preempt", {3'b0, pre4}, 4'b0000);
        req4 = 4'b1000;
        tick();
        chk("force_vol_gap", grant4, 4'b0000);
        chk("force_vol_preempt", {3'b0, pre4}, 4'b0000);
        tick();
        chk("force_regrant_alu", grant4, 4'b1000);
        req4 = 4'b0000;
        tick();
        tick();

        // No contention on dut4: ALU holds well past MAX_HOLD
        req4 = 4'b1000;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("nocont_grant_c%0d", i), grant4, 4'b1000);
            chk($sformatf("nocont_preempt_c%0d", i), {3'b0, pre4}, 4'b0000);
        end
        req4 = 4'b0000;
        tick();
        chk("nocont_release", grant4, 4'b0000);
        tick();

        // Simultaneous release and limit on dut3: MDR owns, PC pending
        req3 = 4'b0100;
        tick();
        chk("simul_c1", grant3, 4'b0100);
        req3 = 4'b0110;
        tick();
        chk("simul_c2", grant3, 4'b0100);
        tick();
        chk("simul_c3", grant3, 4'b0100);
        req3 = 4'b0010;
        tick();
        chk("simul_gap_grant", grant3, 4'b0000);
        chk("simul_gap_preempt", {3'b0, pre3}, 4'b0000);
        tick();
        chk("simul_next_grant", grant3, 4'b0010);
        chk("simul_next_busy", {3'b0, busy3}, 4'b0001);
        req3 = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
